// File: rtl/sram_access_arbiter.sv
// Two-port arbiter sharing one single-port SRAM: one access at a time, registered SRAM controls.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN selects fixed A-over-B priority instead of round-robin.
module sram_access_arbiter #(
   parameter int N         = 8,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [N-1:0]         a_wdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_BITS-1:0] b_addr,
   input  logic [N-1:0]         b_wdata,
   output logic                 a_gnt,
   output logic                 b_gnt,
   output logic                 a_rvalid,
   output logic                 b_rvalid,
   output logic [N-1:0]         a_rdata,
   output logic [N-1:0]         b_rdata,
   output logic                 SRAM_readEnable,
   output logic                 SRAM_writeEnable,
   output logic [ADDR_BITS-1:0] SRAM_address,
   output logic [N-1:0]         SRAM_data_in,
   input  logic [N-1:0]         SRAM_data,
   output logic [1:0]           o_dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_RDATA = 2'd3;

   // Handshake: a requester holds req and payload until its 1-cycle gnt pulse;
   // reads return rvalid (with rdata) exactly one cycle after the gnt cycle.
   logic [1:0]           r_state;
   logic                 r_last_b;
   logic                 r_sel_b;
   logic                 r_a_gnt;
   logic                 r_b_gnt;
   logic                 r_a_rvalid;
   logic                 r_b_rvalid;
   logic                 r_re;
   logic                 r_we;
   logic [ADDR_BITS-1:0] r_addr;
   logic [N-1:0]         r_wdata;

   logic                 w_any_req;
   logic                 w_pick_b;
   logic                 w_sel_we;

   assign w_any_req = a_req | b_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign w_pick_b = b_req & ~a_req;
`else
   // On a tie the port that did not win last time goes next.
   assign w_pick_b = b_req & (~a_req | ~r_last_b);
`endif

   assign w_sel_we = w_pick_b ? b_we : a_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_last_b   <= 1'b1;
         r_sel_b    <= 1'b0;
         r_a_gnt    <= 1'b0;
         r_b_gnt    <= 1'b0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_re       <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_a_gnt    <= 1'b0;
         r_b_gnt    <= 1'b0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_re       <= 1'b0;
         r_we       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_sel_b  <= w_pick_b;
                  r_last_b <= w_pick_b;
                  r_addr   <= w_pick_b ? b_addr : a_addr;
                  r_wdata  <= w_pick_b ? b_wdata : a_wdata;
                  r_a_gnt  <= ~w_pick_b;
                  r_b_gnt  <= w_pick_b;
                  if (w_sel_we) begin
                     r_we    <= 1'b1;
                     r_state <= S_WRITE;
                  end else begin
                     r_re    <= 1'b1;
                     r_state <= S_READ;
                  end
               end
            end
            S_WRITE: r_state <= S_IDLE;
            S_READ: begin
               r_a_rvalid <= ~r_sel_b;
               r_b_rvalid <= r_sel_b;
               r_state    <= S_RDATA;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Enables and rvalid are masked by rst so an access caught by reset never completes.
   assign SRAM_writeEnable = r_we & ~rst;
   assign SRAM_readEnable  = r_re & ~rst;
   assign SRAM_address     = r_addr;
   assign SRAM_data_in     = r_wdata;
   assign a_gnt            = r_a_gnt;
   assign b_gnt            = r_b_gnt;
   assign a_rvalid         = r_a_rvalid & ~rst;
   assign b_rvalid         = r_b_rvalid & ~rst;
   assign a_rdata          = a_rvalid ? SRAM_data : '0;
   assign b_rdata          = b_rvalid ? SRAM_data : '0;
   assign o_dbg_state      = r_state;

   a_gnt_excl : assert property (@(posedge clk) disable iff (rst) !(r_a_gnt && r_b_gnt));
   a_en_excl  : assert property (@(posedge clk) disable iff (rst) !(r_re && r_we));

endmodule
